// File: rtl/led_chaser_seq.sv
// LED bar chaser stepped by rising edges of a slow divider output, all in the clk domain.
// Optional macro LED_BOUNCE_EN alternates the sweep direction every full cycle.
module led_chaser_seq #(
    parameter int N_LED      = 8,
    parameter int HOLD_TICKS = 2,
    parameter int CW         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             step_in,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             cycle_done,
    output logic             dir
);

    // state  | meaning
    // IDLE   | disabled, bar dark, waiting for en
    // FILL   | lighting one LED per tick
    // HOLD_F | bar full, counting hold ticks
    // CLEAR  | darkening one LED per tick
    // HOLD_E | bar empty, counting hold ticks; exit ends a cycle
    typedef enum logic [2:0] {IDLE, FILL, HOLD_F, CLEAR, HOLD_E} state_t;

    localparam logic [CW-1:0] LAST_LED  = CW'(N_LED - 1);
    localparam logic [CW-1:0] LAST_HOLD = CW'(HOLD_TICKS - 1);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [N_LED-1:0]   led_nx;
    logic [N_LED-1:0]   fill_val, clear_val;
    logic               step_q;
    logic               tick;
    logic               done_nx;

    assign tick = step_in & ~step_q;
    assign busy = (state != IDLE);

    // dir=0 sweeps from the MSB end, dir=1 from the LSB end
    assign fill_val  = dir ? {led[N_LED-2:0], 1'b1} : {1'b1, led[N_LED-1:1]};
    assign clear_val = dir ? {led[N_LED-2:0], 1'b0} : {1'b0, led[N_LED-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            led        <= '0;
            step_q     <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            led        <= led_nx;
            step_q     <= step_in;
            cycle_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        led_nx   = led;
        done_nx  = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            led_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // leaving IDLE does not wait for, or consume, a tick
                    state_nx = FILL;
                    cnt_nx   = '0;
                    led_nx   = '0;
                end
                FILL: if (tick) begin
                    led_nx = fill_val;
                    if (cnt == LAST_LED) begin
                        state_nx = HOLD_F;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                HOLD_F: if (tick) begin
                    if (cnt == LAST_HOLD) begin
                        state_nx = CLEAR;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                CLEAR: if (tick) begin
                    led_nx = clear_val;
                    if (cnt == LAST_LED) begin
                        state_nx = HOLD_E;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                HOLD_E: if (tick) begin
                    if (cnt == LAST_HOLD) begin
                        state_nx = FILL;
                        cnt_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    led_nx   = '0;
                end
            endcase
        end
    end

`ifdef LED_BOUNCE_EN
    logic dir_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q <= 1'b0;
        end else if (!en || state == IDLE) begin
            dir_q <= 1'b0;
        end else if (done_nx) begin
            dir_q <= ~dir_q;
        end
    end

    assign dir = dir_q;
`else
    assign dir = 1'b0;
`endif

endmodule

// File: tb/tb_led_chaser_seq.sv
// Self-checking bench for led_chaser_seq: directed sequences plus randomized stimulus vs a
// position-in-period reference model. Define LED_BOUNCE_EN for both bench and RTL to test bouncing.
module tb_led_chaser_seq;

    localparam int N      = 8;
    localparam int H      = 2;
    localparam int PERIOD = 2 * N + 2 * H;
`ifdef LED_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         step_in = 1'b0;
    logic [N-1:0] led;
    logic         busy;
    logic         cycle_done;
    logic         dir;

    int checks = 0;
    int errors = 0;

    led_chaser_seq #(.N_LED(N), .HOLD_TICKS(H), .CW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .step_in    (step_in),
        .led        (led),
        .busy       (busy),
        .cycle_done (cycle_done),
        .dir        (dir)
    );

    always #5 clk = ~clk;

    // Reference model: whether running, and how many ticks into the current period we are.
    bit m_act  = 1'b0;
    int m_pos  = 0;
    bit m_sq   = 1'b0;
    bit m_done = 1'b0;
    bit m_dir  = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        bit t;
        if (!reset_n) begin
            m_act = 0; m_pos = 0; m_sq = 0; m_done = 0; m_dir = 0;
        end else begin
            t      = step_in && !m_sq;
            m_sq   = step_in;
            m_done = 0;
            if (!en) begin
                m_act = 0; m_pos = 0; m_dir = 0;
            end else if (!m_act) begin
                m_act = 1; m_pos = 0;
            end else if (t) begin
                m_pos = m_pos + 1;
                if (m_pos == PERIOD) begin
                    m_pos  = 0;
                    m_done = 1;
                    if (BOUNCE) m_dir = !m_dir;
                end
            end
        end
    end

    function automatic logic [N-1:0] exp_led(input bit act, input int p, input bit d);
        int full = (1 << N) - 1;
        int v;
        if (!act)               v = 0;
        else if (p <= N)        v = d ? ((1 << p) - 1) : (full & ~(full >> p));
        else if (p <= N + H)    v = full;
        else if (p <= 2*N + H)  v = d ? ((full << (p - N - H)) & full) : (full >> (p - N - H));
        else                    v = 0;
        return v[N-1:0];
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; step_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== '0)        begin errors++; $display("FAIL reset_led got %h want 00", led); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cycle_done !== 0)  begin errors++; $display("FAIL reset_done got %b want 0", cycle_done); end
        checks++; if (dir !== 1'b0)      begin errors++; $display("FAIL reset_dir got %b want 0", dir); end
        reset_n = 1'b1;
    endtask

    task automatic test_full_cycle();
        logic [N-1:0] tab [1:20] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                                     8'hFF, 8'hFF,
                                     8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
                                     8'h00, 8'h00};
        int n_done = 0;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || led !== '0) begin
            errors++; $display("FAIL start busy=%b led=%h want busy=1 led=00", busy, led);
        end
        for (int r = 1; r <= 20; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (c != 0) @(negedge clk);
                checks++; if (led !== exp_led(m_act, m_pos, m_dir) || cycle_done !== m_done) begin
                    errors++; $display("FAIL cycle_model r=%0d c=%0d led=%h done=%b want led=%h done=%b",
                                       r, c, led, cycle_done, exp_led(m_act, m_pos, m_dir), m_done);
                end
                if (cycle_done === 1'b1) n_done++;
                if (c == 1) begin
                    checks++; if (led !== tab[r] || busy !== 1'b1 || cycle_done !== (r == 20)) begin
                        errors++; $display("FAIL cycle_step r=%0d led=%h busy=%b done=%b want led=%h busy=1 done=%b",
                                           r, led, busy, cycle_done, tab[r], (r == 20));
                    end
                end
                step_in = (c < 3);
            end
        end
        @(negedge clk);
        checks++; if (n_done != 1) begin errors++; $display("FAIL done_count got %0d want 1", n_done); end
`ifdef LED_BOUNCE_EN
        step_in = 1'b1;
        @(negedge clk);
        checks++; if (led !== 8'h01 || dir !== 1'b1) begin
            errors++; $display("FAIL bounce_fill led=%h dir=%b want led=01 dir=1", led, dir);
        end
        repeat (2) @(negedge clk);
        step_in = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_long_high();
        logic [N-1:0] prev;
        int changes = 0;
        prev = led;
        step_in = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++; if (led !== exp_led(m_act, m_pos, m_dir)) begin
                errors++; $display("FAIL long_high c=%0d led=%h want %h", c, led, exp_led(m_act, m_pos, m_dir));
            end
            if (led !== prev) changes++;
            prev = led;
        end
        step_in = 1'b0;
        checks++; if (changes != 1) begin errors++; $display("FAIL long_high_advances got %0d want 1", changes); end
    endtask

    task automatic test_en_drop();
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            step_in = 1'b1;
            repeat (3) @(negedge clk);
            step_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        checks++; if (led !== 8'hF0) begin errors++; $display("FAIL en_drop_pre led=%h want F0", led); end
        en = 1'b0; step_in = 1'b1;
        @(negedge clk);
        checks++; if (led !== '0 || busy !== 1'b0 || dir !== 1'b0) begin
            errors++; $display("FAIL en_drop led=%h busy=%b dir=%b want 00 0 0", led, busy, dir);
        end
        step_in = 1'b0; en = 1'b1;
        @(negedge clk);
        checks++; if (led !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL en_restart led=%h busy=%b want 00 1", led, busy);
        end
        step_in = 1'b1;
        @(negedge clk);
        checks++; if (led !== 8'h80) begin errors++; $display("FAIL en_restart_tick led=%h want 80", led); end
        step_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        for (int g = 0; g < 40 && m_pos < N + H + 3; g++) begin
            step_in = 1'b1;
            repeat (3) @(negedge clk);
            step_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        checks++; if (led !== 8'h1F) begin errors++; $display("FAIL mid_clear_pre led=%h want 1F", led); end
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        checks++; if (led !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset led=%h busy=%b want 00 0", led, busy);
        end
        @(negedge clk); step_in = 1'b1; reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (led !== '0 || busy !== 1'b1) begin
                errors++; $display("FAIL high_at_release c=%0d led=%h busy=%b want 00 1", c, led, busy);
            end
        end
        step_in = 1'b0;
        @(negedge clk); step_in = 1'b1;
        @(negedge clk);
        checks++; if (led !== exp_led(1'b1, 1, 1'b0) || led !== exp_led(m_act, m_pos, m_dir)) begin
            errors++; $display("FAIL post_reset_tick led=%h want 80", led);
        end
        step_in = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            checks++; if (led !== exp_led(m_act, m_pos, m_dir) || busy !== m_act ||
                          cycle_done !== m_done || dir !== m_dir) begin
                errors++; $display("FAIL random c=%0d led=%h busy=%b done=%b dir=%b want %h %b %b %b",
                                   c, led, busy, cycle_done, dir,
                                   exp_led(m_act, m_pos, m_dir), m_act, m_done, m_dir);
            end
            en = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) < 3) step_in = ~step_in;
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_long_high();
        test_en_drop();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
